// File: rtl/imem_responder.sv
// Loadable, PC-addressed instruction store: program words are loaded sequentially, then fetches answer in one cycle.
// Latency 1 cycle fetch->instruction; load_ready deasserts when full, and fetches are ignored outside RUN.
// Backpressure: a load word is taken only when load_valid && load_ready; words offered while full are dropped.
module imem_responder #(
   parameter int          DEPTH    = 64,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       load_en,
   input  logic                       load_valid,
   input  logic [31:0]                load_data,
   output logic                       load_ready,
   output logic [$clog2(DEPTH):0]     load_count,
   input  logic                       fetch_req,
   input  logic [31:0]                pc,
   output logic [31:0]                instruction,
   output logic                       instr_valid,
   output logic                       fetch_fault,
   output logic                       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FAULT} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  count_nxt;
   logic [31:0]    instr_nxt;
   logic           vld_nxt;
   logic           flt_nxt;
   logic           wr_en;
   logic [29:0]    word_idx;
   logic           in_range;
   logic [31:0]    rd_word;
   logic [31:0]    mem [DEPTH];

   assign word_idx   = pc[31:2];
   // Full 30-bit compare so large PCs never alias onto low words.
   assign in_range   = word_idx < {{(30-CW){1'b0}}, load_count};
   assign rd_word    = mem[pc[AW+1:2]];
   assign load_ready = (state == S_LOAD) && (load_count < CW'(DEPTH));
   assign wr_en      = load_ready && load_valid;
   assign busy       = (state == S_LOAD);

   always_comb begin
      state_nxt = state;
      count_nxt = load_count;
      instr_nxt = instruction;
      vld_nxt   = 1'b0;
      flt_nxt   = fetch_fault;
      case (state)
         S_IDLE: begin
            if (load_en) begin
               state_nxt = S_LOAD;
               count_nxt = '0;
            end
         end
         S_LOAD: begin
            if (wr_en) count_nxt = load_count + CW'(1);
            if (!load_en) state_nxt = (load_count != '0) ? S_RUN : S_IDLE;
         end
         S_RUN: begin
            if (load_en) begin
               state_nxt = S_LOAD;
               count_nxt = '0;
            end else if (fetch_req) begin
               if (pc[1:0] != 2'b00) begin
                  instr_nxt = NOP_WORD;
                  flt_nxt   = 1'b1;
                  state_nxt = S_FAULT;
               end else begin
                  instr_nxt = in_range ? rd_word : NOP_WORD;
                  vld_nxt   = 1'b1;
               end
            end
         end
         S_FAULT: begin
            if (load_en) begin
               state_nxt = S_LOAD;
               count_nxt = '0;
               flt_nxt   = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= S_IDLE;
         load_count  <= '0;
         instruction <= NOP_WORD;
         instr_valid <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         state       <= state_nxt;
         load_count  <= count_nxt;
         instruction <= instr_nxt;
         instr_valid <= vld_nxt;
         fetch_fault <= flt_nxt;
      end
   end

   // Program storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[load_count[AW-1:0]] <= load_data;
   end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (DEPTH 64 and 4) share stimulus and are checked each cycle
// against a per-instance reference model, plus directed literal checks from the program table.
module tb_imem_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int ST_IDLE = 0, ST_LOAD = 1, ST_RUN = 2, ST_FAULT = 3;

   logic        clk = 1'b0;
   logic        nrst;
   logic        load_en, load_valid, fetch_req;
   logic [31:0] load_data, pc;

   logic        rdy0, vld0, flt0, busy0, rdy1, vld1, flt1, busy1;
   logic [6:0]  cnt0;
   logic [2:0]  cnt1;
   logic [31:0] ins0, ins1;

   int n_chk = 0;
   int n_err = 0;

   int          m_st  [2];
   int          m_cnt [2];
   int          m_dep [2] = '{64, 4};
   logic [31:0] m_ins [2];
   logic        m_vld [2];
   logic        m_flt [2];
   logic [31:0] m_mem [2][1024];

   logic [31:0] prog [6] = '{32'h3e800093, 32'h83000113, 32'h3e906193,
                             32'h45707213, 32'h3f31f213, 32'h0aa00513};

   always #5 clk = ~clk;

   imem_responder #(.DEPTH(64)) u0 (
      .clk(clk), .nrst(nrst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
      .load_ready(rdy0), .load_count(cnt0), .fetch_req(fetch_req), .pc(pc),
      .instruction(ins0), .instr_valid(vld0), .fetch_fault(flt0), .busy(busy0));

   imem_responder #(.DEPTH(4)) u1 (
      .clk(clk), .nrst(nrst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
      .load_ready(rdy1), .load_count(cnt1), .fetch_req(fetch_req), .pc(pc),
      .instruction(ins1), .instr_valid(vld1), .fetch_fault(flt1), .busy(busy1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = ST_IDLE; m_cnt[k] = 0; m_ins[k] = NOP; m_vld[k] = 1'b0; m_flt[k] = 1'b0;
      end
   endtask

   // One clock edge of behaviour, straight from the operating rules.
   task automatic model_step(input int k);
      int nst;
      int ncnt;
      nst = m_st[k];
      ncnt = m_cnt[k];
      m_vld[k] = 1'b0;
      case (m_st[k])
         ST_IDLE: if (load_en) begin nst = ST_LOAD; ncnt = 0; end
         ST_LOAD: begin
            if (load_valid && m_cnt[k] < m_dep[k]) begin
               m_mem[k][m_cnt[k]] = load_data;
               ncnt = m_cnt[k] + 1;
            end
            if (!load_en) nst = (m_cnt[k] > 0) ? ST_RUN : ST_IDLE;
         end
         ST_RUN: begin
            if (load_en) begin
               nst = ST_LOAD; ncnt = 0;
            end else if (fetch_req) begin
               if (pc % 4 != 0) begin
                  m_ins[k] = NOP; m_flt[k] = 1'b1; nst = ST_FAULT;
               end else begin
                  m_ins[k] = ((pc / 4) < m_cnt[k]) ? m_mem[k][pc / 4] : NOP;
                  m_vld[k] = 1'b1;
               end
            end
         end
         default: if (load_en) begin nst = ST_LOAD; ncnt = 0; m_flt[k] = 1'b0; end
      endcase
      m_st[k] = nst;
      m_cnt[k] = ncnt;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ins0"},  ins0,  m_ins[0]);
      chk({tag, ".vld0"},  {31'd0, vld0},  {31'd0, m_vld[0]});
      chk({tag, ".flt0"},  {31'd0, flt0},  {31'd0, m_flt[0]});
      chk({tag, ".cnt0"},  {25'd0, cnt0},  m_cnt[0]);
      chk({tag, ".rdy0"},  {31'd0, rdy0},  {31'd0, m_st[0] == ST_LOAD && m_cnt[0] < 64});
      chk({tag, ".busy0"}, {31'd0, busy0}, {31'd0, m_st[0] == ST_LOAD});
      chk({tag, ".ins1"},  ins1,  m_ins[1]);
      chk({tag, ".vld1"},  {31'd0, vld1},  {31'd0, m_vld[1]});
      chk({tag, ".flt1"},  {31'd0, flt1},  {31'd0, m_flt[1]});
      chk({tag, ".cnt1"},  {29'd0, cnt1},  m_cnt[1]);
      chk({tag, ".rdy1"},  {31'd0, rdy1},  {31'd0, m_st[1] == ST_LOAD && m_cnt[1] < 4});
      chk({tag, ".busy1"}, {31'd0, busy1}, {31'd0, m_st[1] == ST_LOAD});
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      if (nrst) begin
         model_step(0);
         model_step(1);
      end
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic le, input logic lv, input logic [31:0] ld,
                        input logic fr, input logic [31:0] p);
      load_en = le; load_valid = lv; load_data = ld; fetch_req = fr; pc = p;
   endtask

   initial begin
      nrst = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      cyc("rst");
      cyc("rst");
      chk("rst_instr", ins0, NOP);
      chk("rst_cnt", {25'd0, cnt0}, 0);
      nrst = 1'b1;

      // fetch in IDLE gives nothing
      drive(0, 0, 0, 1, 0);
      cyc("idle_fetch");
      chk("idle_vld", {31'd0, vld0}, 0);

      // enter load; word offered in the entry cycle is not taken
      drive(1, 1, 32'hdead_beef, 0, 0);
      cyc("load_entry");
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, prog[i], 0, 0);
         cyc($sformatf("load%0d", i));
      end
      chk("cnt_after5", {25'd0, cnt0}, 5);
      chk("cnt_full4", {29'd0, cnt1}, 4);
      drive(0, 0, 0, 0, 0);
      cyc("to_run");

      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 1, 32'(i * 4));
         cyc($sformatf("fetch%0d", i));
         chk($sformatf("fetch_word%0d", i), ins0, prog[i]);
         chk($sformatf("fetch_vld%0d", i), {31'd0, vld0}, 1);
      end
      drive(0, 0, 0, 1, 20);
      cyc("oor20");
      chk("oor20_ins", ins0, NOP);
      chk("oor20_vld", {31'd0, vld0}, 1);
      drive(0, 0, 0, 1, 32'h400);
      cyc("oor400");
      chk("oor400_ins", ins0, NOP);
      drive(0, 0, 0, 0, 0);
      cyc("idle_run");

      // misaligned fetch -> sticky fault
      drive(0, 0, 0, 1, 6);
      cyc("misal");
      chk("misal_flt", {31'd0, flt0}, 1);
      chk("misal_vld", {31'd0, vld0}, 0);
      drive(0, 0, 0, 1, 0);
      cyc("fault_ign");
      chk("fault_ign_vld", {31'd0, vld0}, 0);
      drive(1, 0, 0, 0, 0);
      cyc("fault_clr");
      chk("fault_clr_flt", {31'd0, flt0}, 0);
      chk("fault_clr_busy", {31'd0, busy0}, 1);

      // six words into a depth-4 store
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, prog[5 - i], 0, 0);
         cyc($sformatf("full%0d", i));
      end
      chk("full_cnt", {29'd0, cnt1}, 4);
      chk("full_rdy", {31'd0, rdy1}, 0);
      drive(0, 0, 0, 0, 0);
      cyc("full_run");
      drive(0, 0, 0, 1, 12);
      cyc("full_pc12");
      chk("full_pc12_ins", ins1, prog[2]);

      // load beats a simultaneous fetch
      drive(1, 0, 0, 1, 0);
      cyc("prio");
      chk("prio_vld", {31'd0, vld0}, 0);
      chk("prio_cnt", {25'd0, cnt0}, 0);

      // async reset in the middle of a load
      drive(1, 1, 32'h1234_5678, 0, 0);
      cyc("preload");
      #2 nrst = 1'b0;
      model_reset();
      #1;
      chk("areset_cnt", {25'd0, cnt0}, 0);
      chk("areset_busy", {31'd0, busy0}, 0);
      check_all("areset");
      cyc("areset_hold");
      nrst = 1'b1;
      drive(0, 0, 0, 0, 0);
      cyc("post_reset");

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int sel;
         if ($urandom_range(0, 24) == 0) load_en = ~load_en;
         load_valid = $urandom_range(0, 1);
         load_data  = $urandom;
         fetch_req  = $urandom_range(0, 2) != 0;
         sel = $urandom_range(0, 39);
         if (sel == 0)      pc = $urandom;
         else if (sel == 1) pc = ($urandom_range(0, 20) << 2) | 32'($urandom_range(1, 3));
         else               pc = $urandom_range(0, 70) << 2;
         cyc("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder on the core's fetch side: holds a program loaded word by word, then answers the core's PC fetch requests with the stored instruction word, one cycle later. It sits between the bench or boot loader and the single-cycle `top`. It replaces direct per-cycle driving of `instruction` with a loadable, PC-addressed instruction source.

## Interface
Parameters:
- DEPTH, 64: instruction words stored; power of two, 4..1024.
- NOP_WORD, 32'h00000013: word returned for unloaded or out-of-range addresses (`addi x0,x0,0`).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- nrst  in  1  reset; one clock; reset is asynchronous and active-low.
- load_en  in  1  level; high requests or holds program-load mode.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  32  program word to store at the next write index.
- load_ready  out  1  block accepts a load word this cycle.
- load_count  out  $clog2(DEPTH)+1  number of words currently loaded.
- fetch_req  in  1  core requests the instruction at pc.
- pc  in  32  byte address of the requested instruction.
- instruction  out  32  registered fetch response word.
- instr_valid  out  1  instruction carries a response to the previous cycle's request.
- fetch_fault  out  1  sticky misaligned-fetch flag.
- busy  out  1  high in LOAD state.

## Operation
- States: IDLE, LOAD, RUN, FAULT; reset state is IDLE.
- IDLE→LOAD when load_en=1. Entering LOAD clears load_count and the write index to 0.
- LOAD: load_ready = (state==LOAD) && (load_count<DEPTH), combinational from registered state.
  - load_valid && load_ready writes mem[load_count] ← load_data and increments load_count.
  - load_valid while full is dropped; the count stays at DEPTH.
- LOAD, load_en=0: go to RUN if load_count>0, else to IDLE.
- RUN, fetch_req=1, load_en=0:
  - pc[1:0]≠0: next cycle instruction=NOP_WORD, instr_valid=0, fetch_fault=1; state→FAULT.
  - Else let word index w = pc[31:2]. If w<load_count, instruction=mem[w]; otherwise instruction=NOP_WORD. Either way instr_valid=1 the next cycle and there is no fault.
- RUN, fetch_req=0: next cycle instr_valid=0; instruction holds its last value.
- RUN with load_en=1 → LOAD. Load takes priority over a simultaneous fetch_req: no response is issued and instr_valid=0.
- FAULT: fetch_req is ignored and instr_valid=0. fetch_fault stays 1 until load_en=1, which moves to LOAD and clears fetch_fault.
- IDLE, LOAD: fetch_req is ignored and instr_valid=0.
- Memory contents survive LOAD re-entry. Words beyond the new load_count are still unreadable because the w<load_count check applies.
- Address comparison uses the full 30-bit w; no aliasing occurs for pc ≥ 4·DEPTH.

## Timing
- Reset (nrst=0, asynchronous) forces the following immediately:
  - state=IDLE, load_count=0, instruction=NOP_WORD, instr_valid=0, fetch_fault=0, load_ready=0, busy=0.
  - Memory contents are not reset.
- Reset mid-LOAD or mid-fetch drops all progress. After release, the block accepts nothing until load_en is seen in IDLE.
- Load mode entry latency:
  - load_en rising in cycle N puts state=LOAD at edge N+1.
  - First load_ready=1 is in cycle N+1; words presented in cycle N are not taken.
- Load throughput: one word per cycle while load_valid=1.
- Run mode entry latency:
  - load_en falling in cycle M puts state=RUN at edge M+1.
  - A word with load_valid=1 in cycle M is still accepted.
  - The first fetch is accepted in cycle M+1.
- Fetch latency: exactly 1 cycle, request in cycle K → response valid in cycle K+1. Back-to-back requests give one response per cycle.
- busy = (state==LOAD), registered.

## Test plan
- Reset then idle: hold nrst=0 for 2 cycles. Outputs must read instruction=0x00000013, instr_valid=0, load_count=0, load_ready=0, fetch_fault=0. A fetch_req in IDLE must give instr_valid=0.
- Load and fetch:
  - Load 0x3e800093, 0x83000113, 0x3e906193, 0x45707213, 0x3f31f213; load_count must read 5.
  - Fetch pc=0,4,8,12,16 back-to-back. Responses must be those five words, each one cycle after its request.
- Out-of-range fetch with 5 words loaded: pc=20 → 0x00000013, valid=1, fault=0. pc=0x400 → 0x00000013.
- Misaligned fetch: pc=6 → fetch_fault=1, instr_valid=0, state FAULT. A later pc=0 is ignored. load_en=1 clears fetch_fault and enters LOAD.
- Full load with DEPTH=4: present 6 words. load_ready must drop after 4 are accepted, with load_count=4. Words 5 and 6 are dropped, and fetch pc=12 returns the 4th word.
- Priority and reset:
  - load_en=1 together with fetch_req in RUN gives no response, and load_count reads 0 next cycle.
  - nrst pulsed low mid-load must force IDLE and load_count=0 immediately, asynchronously.
